// File: rtl/bcd_countdown_core.sv
// BCD countdown timer core: digit entry, start/pause/resume, one-shot or auto-reload,
// with a one-cycle finish pulse and a timed alarm level driven from the 1 kHz strobe.
module bcd_countdown_core #(
    parameter int N_DIGITS = 8,
    parameter int TICK_DIV = 10,
    parameter int ALARM_MS = 3000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pls_1k,
    input  logic                  i_digit_vld,
    input  logic [3:0]            i_digit,
    input  logic                  i_start,
    input  logic                  i_clear,
    input  logic                  i_reload_mode,
    output logic [4*N_DIGITS-1:0] o_bcd,
    output logic [1:0]            o_state,
    output logic                  o_fin,
    output logic                  o_alarm
);

    localparam int BW = 4 * N_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = $clog2(ALARM_MS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_bcd;
    logic [BW-1:0]   r_preset;
    logic [PW-1:0]   r_presc;
    logic [AW-1:0]   r_alarm_cnt;
    logic            r_mode;
    logic            r_fin;
    logic            r_alarm;

    logic [BW-1:0]   w_bcd_dec;
    logic            w_is_one;
    logic            w_tick;
    logic            w_digit_ok;

    // Ripple-borrow decrement across digits; never used on zero since expiry is caught at one.
    always_comb begin : bcd_decrement
        logic borrow;
        borrow    = 1'b1;
        w_bcd_dec = r_bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (borrow) begin
                if (r_bcd[4*i +: 4] == 4'd0) begin
                    w_bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_bcd_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end
        end
    end

    assign w_is_one   = (r_bcd == BW'(1));
    assign w_tick     = i_pls_1k && (r_presc == PW'(TICK_DIV - 1));
    assign w_digit_ok = i_digit_vld && (i_digit <= 4'd9);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bcd       <= '0;
            r_preset    <= '0;
            r_presc     <= '0;
            r_alarm_cnt <= '0;
            r_mode      <= 1'b0;
            r_fin       <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            if (i_clear) begin
                r_state     <= ST_IDLE;
                r_bcd       <= '0;
                r_presc     <= '0;
                r_alarm_cnt <= '0;
                r_alarm     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            if (r_bcd != '0) begin
                                r_preset <= r_bcd;
                                r_mode   <= i_reload_mode;
                                r_presc  <= '0;
                                r_state  <= ST_RUN;
                            end
                        end else if (w_digit_ok) begin
                            r_bcd <= {r_bcd[BW-5:0], i_digit};
                        end
                    end
                    ST_RUN: begin
                        // A start request pauses and swallows any coincident strobe or tick.
                        if (i_start) begin
                            r_state <= ST_PAUSE;
                        end else if (w_tick) begin
                            r_presc <= '0;
                            if (w_is_one) begin
                                r_fin <= 1'b1;
                                if (r_mode) begin
                                    r_bcd <= r_preset;
                                end else begin
                                    r_bcd       <= '0;
                                    r_state     <= ST_DONE;
                                    r_alarm_cnt <= '0;
                                    r_alarm     <= 1'b1;
                                end
                            end else begin
                                r_bcd <= w_bcd_dec;
                            end
                        end else if (i_pls_1k) begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (i_start) begin
                            r_state <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        if (i_start) begin
                            r_state <= ST_IDLE;
                            r_bcd   <= r_preset;
                            r_alarm <= 1'b0;
                        end else if (i_pls_1k && r_alarm) begin
                            if (r_alarm_cnt == AW'(ALARM_MS - 1)) begin
                                r_alarm <= 1'b0;
                            end
                            r_alarm_cnt <= r_alarm_cnt + AW'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_bcd   = r_bcd;
    assign o_state = r_state;
    assign o_fin   = r_fin;
    assign o_alarm = r_alarm;

endmodule
